i2c_slave_read_frame: RTL and testbench
=======================================

Name: i2c_slave_read_frame

Overview:
Multi-word I2C slave receiver. It is armed by a pulse at an SCL rising edge and then samples up to MAX_WORDS words of WORD_BITS bits each. After every word it drives the ACK/NACK bit on SDA. It sits between the slave bit/edge layer and the slave control FSM, replacing per-byte sequencing in the controller with one frame-level transaction.

Parameters:
WORD_BITS, 8, bits per word before each ACK slot (legal range 1..16).
MAX_WORDS, 4, largest word count per frame (legal range 1..256).
MSB_FIRST, 1, 1 = first received bit lands in data[WORD_BITS-1]; 0 = first bit lands in data[0].
CW, $clog2(MAX_WORDS+1), width of word_count and word_index.

Ports:
clock  input  1  system clock; the only clock.
reset  input  1  synchronous, active-high reset.
enable  input  1  start pulse; honoured only when idle and coincident with an SCL rising edge.
word_count  input  CW  words to receive; latched on the accepted enable; 0 is treated as 1; values above MAX_WORDS clamp to MAX_WORDS.
ack_last  input  1  latched on enable; 1 = ACK the final word, 0 = NACK it. Non-final words are always ACKed.
scl  input  1  I2C clock, already synchronised to clock.
sda  input  1  I2C data, already synchronised to clock.
sda_pull  output  1  1 = pull SDA low (open-drain); 0 = release.
data  output  WORD_BITS  most recently completed word; holds until the next word completes.
data_valid  output  1  one-cycle pulse when data updates.
word_index  output  CW  index (0-based) of the word in data.
busy  output  1  high from the accepted enable until finish or error.
finish  output  1  one-cycle pulse when the frame completes normally.
error  output  1  sticky; cleared by reset or by the next accepted enable.

Behaviour:
- Reset values: sda_pull=0, data=0, data_valid=0, word_index=0, busy=0, finish=0, error=0, state=IDLE.
- Inputs are sampled in the same cycle as reset; reset mid-frame aborts at once with no finish pulse, and sda_pull returns to 0 on the next edge.
- Edge detection: scl_q register, reset value 1. rise = !scl_q & scl; fall = scl_q & !scl.
- States:
  - IDLE: on enable & scl & rise, sample sda as bit 0, latch word_count/ack_last, set busy, clear error, bit_cnt=1, go to RECV. If WORD_BITS==1, go directly to ACK_WAIT. Enable under any other condition is ignored.
  - RECV: sample sda on each rise. After bit WORD_BITS-1 is sampled, go to ACK_WAIT. data, data_valid and word_index update in the cycle after the last sample.
  - ACK_WAIT: on fall, set sda_pull = (not final word) | ack_last; go to ACK_HIGH.
  - ACK_HIGH: wait for rise, then go to ACK_REL.
  - ACK_REL: on fall, set sda_pull=0. If this was the final word, pulse finish, clear busy and go to IDLE. Otherwise increment the word counter, set bit_cnt=0 and go to RECV.
- Bus-condition check: while in RECV with scl high and not in a rise cycle, any sda change (START or STOP) causes:
  - error=1, busy=0, sda_pull=0, return to IDLE;
  - no finish pulse; the partial word is discarded (data is not updated).
- While in ACK_HIGH, sda is not checked, because the bus holds our own drive.
- The word counter wraps only through reset or a new frame; the final word is word_index == latched_count-1.
- Simultaneous events: an enable while busy is ignored. A fall and the error check can never coincide, because the check requires scl high.
- Latency:
  - First bit is sampled in the enable cycle.
  - data_valid follows the final-bit rise by 1 clock.
  - sda_pull asserts 1 clock after the next fall.
  - finish asserts 1 clock after the fall that ends the final ACK slot.

Decomposition:
- Package i2c_pkg: state enum (IDLE, RECV, ACK_WAIT, ACK_HIGH, ACK_REL), ACK=1'b0 and NACK=1'b1 constants, and a clamp function for word_count.
- One sub-module, i2c_scl_edge_detect:
  - ports: clock, reset, scl, sda; outputs rise, fall, sda_changed_high;
  - shared with other slave receive blocks.
- Shift/assembly logic and the FSM live in the top module.

Test Plan:
- Default params, word_count=1, ack_last=1, bits 1010_0101 → data=8'hA5, data_valid ×1, sda_pull high for exactly one SCL period after the 8th fall, then finish pulse, busy=0.
- word_count=3, ack_last=0, words 8'h12, 8'h34, 8'h56 → word_index 0, 1, 2 with matching data; ACK on words 0 and 1; sda_pull stays 0 in slot 3 (NACK); one finish pulse.
- MSB_FIRST=0, WORD_BITS=8, bits 1,0,0,0,0,0,0,0 sent first-to-last → data=8'h01.
- STOP (sda 0→1 while scl high) after 4 bits → error=1, busy=0, no finish, no data_valid, sda_pull=0. A subsequent valid enable clears error.
- reset asserted during an ACK slot of word 1 of 2 → next clock: all outputs at reset values, sda_pull=0; a later frame operates normally.
- Second enable during RECV, plus enable with scl low while idle → both ignored; the in-flight frame completes unchanged. word_count=0 → behaves as 1 word.

Source files
------------

// File: rtl/i2c_slave_read_frame_pkg.sv
// Shared types and helpers for the I2C slave frame receiver.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    ACK_WAIT,
    ACK_HIGH,
    ACK_REL
  } state_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  // A request of zero words still receives one; oversize requests saturate.
  function automatic int unsigned clamp_count(input int unsigned count, input int unsigned max_words);
    if (count == 0) return 1;
    else if (count > max_words) return max_words;
    else return count;
  endfunction

endpackage

// File: rtl/i2c_scl_edge_detect.sv
// SCL edge detector plus START/STOP detector (SDA moving while SCL stays high).
module i2c_scl_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic scl,
  input  logic sda,
  output logic rise,
  output logic fall,
  output logic sda_changed_high
);

  logic scl_q;
  logic sda_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl;
      sda_q <= sda;
    end
  end

  assign rise = !scl_q & scl;
  assign fall = scl_q & !scl;
  // Requiring scl_q excludes the rise cycle, where sda is legitimately sampled.
  assign sda_changed_high = scl_q & scl & (sda != sda_q);

endmodule

// File: rtl/i2c_slave_read_frame.sv
// Frame-level I2C slave receiver: collects up to MAX_WORDS words and drives ACK/NACK after each.
module i2c_slave_read_frame
  import i2c_pkg::*;
#(
  parameter int WORD_BITS = 8,
  parameter int MAX_WORDS = 4,
  parameter int MSB_FIRST = 1,
  parameter int CW        = $clog2(MAX_WORDS + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [CW-1:0]        word_count,
  input  logic                 ack_last,
  input  logic                 scl,
  input  logic                 sda,
  output logic                 sda_pull,
  output logic [WORD_BITS-1:0] data,
  output logic                 data_valid,
  output logic [CW-1:0]        word_index,
  output logic                 busy,
  output logic                 finish,
  output logic                 error
);

  localparam int BW = $clog2(WORD_BITS + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WORD_BITS - 1);

  logic rise, fall, sda_changed_high;

  i2c_scl_edge_detect u_edge (
    .clock            (clock),
    .reset            (reset),
    .scl              (scl),
    .sda              (sda),
    .rise             (rise),
    .fall             (fall),
    .sda_changed_high (sda_changed_high)
  );

  state_t               state_reg, state_next;
  logic [BW-1:0]        bit_cnt_reg, bit_cnt_next;
  logic [WORD_BITS-1:0] shift_reg, shift_next;
  logic [CW-1:0]        count_reg, count_next;
  logic                 ack_last_reg, ack_last_next;
  logic [CW-1:0]        word_ctr_reg, word_ctr_next;
  logic [WORD_BITS-1:0] data_reg, data_next;
  logic                 data_valid_reg, data_valid_next;
  logic [CW-1:0]        word_index_reg, word_index_next;
  logic                 busy_reg, busy_next;
  logic                 finish_reg, finish_next;
  logic                 error_reg, error_next;
  logic                 sda_pull_reg, sda_pull_next;

  logic [WORD_BITS-1:0] shifted;
  logic                 is_final;
  logic                 ack_bit;

  function automatic logic [WORD_BITS-1:0] shift_in(input logic [WORD_BITS-1:0] cur, input logic bit_in);
    logic [WORD_BITS-1:0] r;
    if (MSB_FIRST != 0) begin
      r = cur << 1;
      r[0] = bit_in;
    end else begin
      r = cur >> 1;
      r[WORD_BITS-1] = bit_in;
    end
    return r;
  endfunction

  assign shifted  = shift_in(shift_reg, sda);
  assign is_final = (word_ctr_reg == count_reg - CW'(1));
  assign ack_bit  = (!is_final || ack_last_reg) ? ACK : NACK;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      count_reg      <= CW'(1);
      ack_last_reg   <= 1'b0;
      word_ctr_reg   <= '0;
      data_reg       <= '0;
      data_valid_reg <= 1'b0;
      word_index_reg <= '0;
      busy_reg       <= 1'b0;
      finish_reg     <= 1'b0;
      error_reg      <= 1'b0;
      sda_pull_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      count_reg      <= count_next;
      ack_last_reg   <= ack_last_next;
      word_ctr_reg   <= word_ctr_next;
      data_reg       <= data_next;
      data_valid_reg <= data_valid_next;
      word_index_reg <= word_index_next;
      busy_reg       <= busy_next;
      finish_reg     <= finish_next;
      error_reg      <= error_next;
      sda_pull_reg   <= sda_pull_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    shift_next      = shift_reg;
    count_next      = count_reg;
    ack_last_next   = ack_last_reg;
    word_ctr_next   = word_ctr_reg;
    data_next       = data_reg;
    data_valid_next = 1'b0;
    word_index_next = word_index_reg;
    busy_next       = busy_reg;
    finish_next     = 1'b0;
    error_next      = error_reg;
    sda_pull_next   = sda_pull_reg;

    case (state_reg)
      IDLE: begin
        if (enable && scl && rise) begin
          count_next    = CW'(clamp_count(32'(word_count), MAX_WORDS));
          ack_last_next = ack_last;
          busy_next     = 1'b1;
          error_next    = 1'b0;
          word_ctr_next = '0;
          shift_next    = shifted;
          bit_cnt_next  = BW'(1);
          if (WORD_BITS == 1) begin
            data_next       = shifted;
            data_valid_next = 1'b1;
            word_index_next = '0;
            state_next      = ACK_WAIT;
          end else begin
            state_next = RECV;
          end
        end
      end
      RECV: begin
        if (sda_changed_high) begin
          // START/STOP inside a word aborts the frame; the partial word is dropped.
          error_next    = 1'b1;
          busy_next     = 1'b0;
          sda_pull_next = 1'b0;
          state_next    = IDLE;
        end else if (rise) begin
          shift_next = shifted;
          if (bit_cnt_reg == LAST_BIT) begin
            data_next       = shifted;
            data_valid_next = 1'b1;
            word_index_next = word_ctr_reg;
            state_next      = ACK_WAIT;
          end else begin
            bit_cnt_next = bit_cnt_reg + BW'(1);
          end
        end
      end
      ACK_WAIT: begin
        if (fall) begin
          sda_pull_next = (ack_bit == ACK);
          state_next    = ACK_HIGH;
        end
      end
      ACK_HIGH: begin
        if (rise) state_next = ACK_REL;
      end
      ACK_REL: begin
        if (fall) begin
          sda_pull_next = 1'b0;
          if (is_final) begin
            finish_next = 1'b1;
            busy_next   = 1'b0;
            state_next  = IDLE;
          end else begin
            word_ctr_next = word_ctr_reg + CW'(1);
            bit_cnt_next  = '0;
            state_next    = RECV;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign sda_pull   = sda_pull_reg;
  assign data       = data_reg;
  assign data_valid = data_valid_reg;
  assign word_index = word_index_reg;
  assign busy       = busy_reg;
  assign finish     = finish_reg;
  assign error      = error_reg;

endmodule

// File: tb/tb_i2c_slave_read_frame.sv
// Scoreboard bench for i2c_slave_read_frame: bit-level SCL/SDA driver, word queue, per-scenario tasks.
module tb_i2c_slave_read_frame;

  localparam int H = 4;  // SCL half-period in clocks

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [2:0] word_count = 3'd1;
  logic       ack_last = 1'b1;
  logic       scl = 1'b0;
  logic       sda = 1'b1;

  logic       sda_pull, data_valid, busy, finish, error;
  logic [7:0] data;
  logic [2:0] word_index;

  logic       l_sda_pull, l_data_valid, l_busy, l_finish, l_error;
  logic [7:0] l_data;
  logic [2:0] l_word_index;

  int n_cmp = 0;
  int n_bad = 0;
  int pull_cycles = 0;
  int finish_cnt = 0;
  int dv_cnt = 0;
  logic [10:0] exp_q[$];

  always #5 clock = ~clock;

  i2c_slave_read_frame dut (
    .clock(clock), .reset(reset), .enable(enable), .word_count(word_count),
    .ack_last(ack_last), .scl(scl), .sda(sda), .sda_pull(sda_pull), .data(data),
    .data_valid(data_valid), .word_index(word_index), .busy(busy), .finish(finish),
    .error(error)
  );

  i2c_slave_read_frame #(.WORD_BITS(8), .MAX_WORDS(4), .MSB_FIRST(0)) dut_lsb (
    .clock(clock), .reset(reset), .enable(enable), .word_count(word_count),
    .ack_last(ack_last), .scl(scl), .sda(sda), .sda_pull(l_sda_pull), .data(l_data),
    .data_valid(l_data_valid), .word_index(l_word_index), .busy(l_busy), .finish(l_finish),
    .error(l_error)
  );

  // Output monitor: pops the scoreboard on every data_valid pulse.
  always @(negedge clock) begin
    logic [10:0] e;
    if (sda_pull) pull_cycles++;
    if (finish) finish_cnt++;
    if (data_valid) begin
      dv_cnt++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected: got idx=%0d data=%h, required no word", word_index, data);
      end else begin
        e = exp_q.pop_front();
        if ({word_index, data} !== e) begin
          n_bad++;
          $display("FAIL sb_word: got idx=%0d data=%h, required idx=%0d data=%h",
                   word_index, data, e[10:8], e[7:0]);
        end else begin
          $display("word idx=%0d data=%h ok", word_index, data);
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_bit(input logic b, input logic en);
    sda = b;
    wait_clk(H);
    scl = 1'b1;
    enable = en;
    wait_clk(1);
    enable = 1'b0;
    wait_clk(H - 1);
    scl = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input logic first, input int idx);
    exp_q.push_back({3'(idx), w});
    for (int i = 7; i >= 0; i--) send_bit(w[i], first && (i == 7));
  endtask

  task automatic ack_slot(output int pulls);
    pull_cycles = 0;
    wait_clk(H);
    scl = 1'b1;
    wait_clk(H);
    scl = 1'b0;
    wait_clk(2);
    pulls = pull_cycles;
  endtask

  task automatic clear_counts();
    wait_clk(1);
    finish_cnt = 0;
    dv_cnt = 0;
  endtask

  task automatic check_end(input string name, input int pulls, input int exp_pulls);
    n_cmp++;
    if (pulls !== exp_pulls) begin
      n_bad++;
      $display("FAIL %s_pull: got %0d cycles, required %0d", name, pulls, exp_pulls);
    end
    n_cmp++;
    if (finish_cnt !== 1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_finish: got finish=%0d busy=%b, required finish=1 busy=0", name, finish_cnt, busy);
    end
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL %s_queue: got %0d pending words, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wait_clk(3);
    n_cmp++;
    if ({busy, finish, error, data_valid, sda_pull, data, word_index} !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_values: got busy=%b fin=%b err=%b dv=%b pull=%b data=%h idx=%0d, required all 0",
               busy, finish, error, data_valid, sda_pull, data, word_index);
    end
    reset = 1'b0;
    wait_clk(2);
    $display("reset check done");
  endtask

  task automatic test_single();
    int p;
    word_count = 3'd1; ack_last = 1'b1;
    clear_counts();
    send_word(8'hA5, 1'b1, 0);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL single_busy: got %b, required 1", busy);
    end
    ack_slot(p);
    check_end("single", p, 2 * H);
    n_cmp++;
    if (dv_cnt !== 1) begin
      n_bad++;
      $display("FAIL single_dv_count: got %0d, required 1", dv_cnt);
    end
    $display("single frame done");
  endtask

  task automatic test_multi();
    logic [7:0] words[3] = '{8'h12, 8'h34, 8'h56};
    int p;
    word_count = 3'd3; ack_last = 1'b0;
    clear_counts();
    for (int k = 0; k < 3; k++) begin
      send_word(words[k], k == 0, k);
      ack_slot(p);
      n_cmp++;
      if (p !== ((k < 2) ? 2 * H : 0)) begin
        n_bad++;
        $display("FAIL multi_pull_w%0d: got %0d cycles, required %0d", k, p, (k < 2) ? 2 * H : 0);
      end
      if (k == 0) begin
        n_cmp++;
        if (finish_cnt !== 0 || busy !== 1'b1) begin
          n_bad++;
          $display("FAIL multi_midframe: got finish=%0d busy=%b, required finish=0 busy=1", finish_cnt, busy);
        end
      end
    end
    check_end("multi", 0, 0);
    $display("multi frame done");
  endtask

  task automatic test_lsb();
    int p;
    word_count = 3'd1; ack_last = 1'b1;
    clear_counts();
    send_word(8'h80, 1'b1, 0);
    ack_slot(p);
    check_end("lsb", p, 2 * H);
    n_cmp++;
    if (l_data !== 8'h01) begin
      n_bad++;
      $display("FAIL lsb_data: got %h, required 01", l_data);
    end
    $display("lsb-first frame done");
  endtask

  task automatic test_stop_error();
    int p;
    word_count = 3'd1; ack_last = 1'b1;
    clear_counts();
    for (int i = 0; i < 4; i++) send_bit(i[0], i == 0);
    sda = 1'b0;
    wait_clk(H);
    scl = 1'b1;
    wait_clk(H);
    sda = 1'b1;  // STOP
    wait_clk(2);
    n_cmp++;
    if ({error, busy, sda_pull} !== 3'b100 || finish_cnt !== 0 || dv_cnt !== 0) begin
      n_bad++;
      $display("FAIL stop_error: got err=%b busy=%b pull=%b fin=%0d dv=%0d, required 1 0 0 0 0",
               error, busy, sda_pull, finish_cnt, dv_cnt);
    end
    scl = 1'b0;
    wait_clk(H);
    send_word(8'h5A, 1'b1, 0);
    n_cmp++;
    if ({error, busy} !== 2'b01) begin
      n_bad++;
      $display("FAIL stop_recover: got err=%b busy=%b, required 0 1", error, busy);
    end
    ack_slot(p);
    check_end("stop_recover", p, 2 * H);
    $display("stop/error scenario done");
  endtask

  task automatic test_reset_mid();
    int p;
    word_count = 3'd2; ack_last = 1'b1;
    clear_counts();
    send_word(8'h11, 1'b1, 0);
    ack_slot(p);
    send_word(8'h22, 1'b0, 1);
    wait_clk(H);
    scl = 1'b1;
    wait_clk(2);
    n_cmp++;
    if (sda_pull !== 1'b1) begin
      n_bad++;
      $display("FAIL rmid_pull_before: got %b, required 1", sda_pull);
    end
    reset = 1'b1;
    wait_clk(1);
    n_cmp++;
    if ({busy, finish, error, data_valid, sda_pull, data, word_index} !== 16'h0) begin
      n_bad++;
      $display("FAIL rmid_values: got busy=%b fin=%b err=%b dv=%b pull=%b data=%h idx=%0d, required all 0",
               busy, finish, error, data_valid, sda_pull, data, word_index);
    end
    reset = 1'b0;
    scl = 1'b0;
    wait_clk(H);
    n_cmp++;
    if (finish_cnt !== 0) begin
      n_bad++;
      $display("FAIL rmid_no_finish: got %0d, required 0", finish_cnt);
    end
    word_count = 3'd1;
    clear_counts();
    send_word(8'h77, 1'b1, 0);
    ack_slot(p);
    check_end("rmid_after", p, 2 * H);
    $display("reset mid-frame scenario done");
  endtask

  task automatic test_ignored();
    logic [7:0] w = 8'h3C;
    int p;
    word_count = 3'd1; ack_last = 1'b1;
    clear_counts();
    enable = 1'b1;  // scl low while idle
    wait_clk(1);
    enable = 1'b0;
    wait_clk(1);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL ign_idle_enable: got busy=%b, required 0", busy);
    end
    exp_q.push_back({3'd0, w});
    for (int i = 7; i >= 0; i--) begin
      if (i == 4) begin
        word_count = 3'd3;
        ack_last = 1'b0;
      end
      send_bit(w[i], (i == 7) || (i == 4));
    end
    ack_slot(p);
    check_end("ign_busy_enable", p, 2 * H);
    word_count = 3'd0; ack_last = 1'b1;
    clear_counts();
    send_word(8'hC3, 1'b1, 0);
    ack_slot(p);
    check_end("count_zero", p, 2 * H);
    $display("ignored-enable and zero-count scenario done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_lsb();
    test_stop_error();
    test_reset_mid();
    test_ignored();
    wait_clk(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
